// File: rtl/dram_arb_pkg.sv
// Shared types, default widths and helpers for the DRAM port arbiter.
package dram_arb_pkg;

   localparam int unsigned DEF_N_PORTS     = 2;
   localparam int unsigned DEF_ADDR_W      = 32;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_TIMEOUT_CYC = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit offset of channel idx inside a packed per-port bus of element width w.
   function automatic int unsigned pack_off(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

   // Width of a port index; at least one bit even for a single port.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: one-hot pick of the first requester after port `last`, wrapping.
module rr_arbiter
   import dram_arb_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]          req,
   input  logic [idx_w(N)-1:0]   last,
   output logic [N-1:0]          grant
);

   localparam int unsigned IW = idx_w(N);

   logic [IW:0]  sh;
   logic [N-1:0] req_rot;
   logic [N-1:0] gnt_rot;

   // Rotate so the port after `last` sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      sh      = {1'b0, last} + (IW+1)'(1);
      req_rot = N'({req, req} >> sh);
      gnt_rot = req_rot & (~req_rot + N'(1));
      grant   = N'({gnt_rot, gnt_rot} >> ((IW+1)'(N) - sh));
   end

endmodule

// File: rtl/dram_port_arb.sv
// Multi-port DRAM arbiter: round-robin grant, single outstanding access, miss stall.
// Optional miss timeout abort enabled by defining DRAM_ARB_TIMEOUT_EN.
module dram_port_arb
   import dram_arb_pkg::*;
#(
   parameter int unsigned N_PORTS     = DEF_N_PORTS,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_PORTS-1:0]          req_valid,
   input  logic [N_PORTS-1:0]          req_we,
   input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
   input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
   output logic [N_PORTS-1:0]          req_ready,
   output logic [N_PORTS-1:0]          resp_valid,
   output logic [DATA_W-1:0]           resp_rdata,
   output logic                        resp_err,
   output logic [ADDR_W-1:0]           addr,
   output logic [DATA_W-1:0]           wdata,
   input  logic [DATA_W-1:0]           rdata,
   output logic                        write_enable_DRAM,
   output logic                        read_enable_DRAM,
   input  logic                        miss
);

   localparam int unsigned IDX_W = idx_w(N_PORTS);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wen_q, wen_d;
   logic                ren_q, ren_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [N_PORTS-1:0]  resp_valid_q, resp_valid_d;
   logic                finish;

`ifdef DRAM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
`endif

   logic [N_PORTS-1:0]  grant;
   logic [IDX_W-1:0]    grant_idx;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [ADDR_W-1:0]   addr_arr  [N_PORTS];
   logic [DATA_W-1:0]   wdata_arr [N_PORTS];

   for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[pack_off(g, ADDR_W) +: ADDR_W];
      assign wdata_arr[g] = req_wdata[pack_off(g, DATA_W) +: DATA_W];
   end

   rr_arbiter #(.N(N_PORTS)) u_rr (
      .req   (req_valid),
      .last  (last_q),
      .grant (grant)
   );

   // Mux out the granted port's request fields.
   always_comb begin
      grant_idx = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (grant[i]) begin
            grant_idx = IDX_W'(i);
            sel_we    = req_we[i];
            sel_addr  = addr_arr[i];
            sel_wdata = wdata_arr[i];
         end
      end
   end

   // Handshake is combinational so the grant lands in the requesting cycle.
   assign req_ready = (state_q == IDLE && !rst) ? grant : '0;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wen_d        = wen_q;
      ren_d        = ren_q;
      rdata_d      = rdata_q;
      resp_valid_d = '0;
      finish       = 1'b0;
`ifdef DRAM_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (|grant) begin
               owner_d = grant_idx;
               last_d  = grant_idx;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               wen_d   = sel_we;
               ren_d   = !sel_we;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!miss) begin
               if (ren_q) rdata_d = rdata;
               finish = 1'b1;
            end
`ifdef DRAM_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               err_d  = 1'b1;
               finish = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Completion (normal or aborted) closes the DRAM access and notifies the owner.
      if (finish) begin
         wen_d        = 1'b0;
         ren_d        = 1'b0;
         resp_valid_d = N_PORTS'(1) << owner_q;
         state_d      = DONE;
`ifdef DRAM_ARB_TIMEOUT_EN
         cnt_d        = '0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_q       <= IDX_W'(N_PORTS - 1);
         addr_q       <= '0;
         wdata_q      <= '0;
         wen_q        <= 1'b0;
         ren_q        <= 1'b0;
         rdata_q      <= '0;
         resp_valid_q <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
         cnt_q        <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wen_q        <= wen_d;
         ren_q        <= ren_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
`ifdef DRAM_ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   assign addr              = addr_q;
   assign wdata             = wdata_q;
   assign write_enable_DRAM = wen_q;
   assign read_enable_DRAM  = ren_q;
   assign resp_valid        = resp_valid_q;
   assign resp_rdata        = rdata_q;
`ifdef DRAM_ARB_TIMEOUT_EN
   assign resp_err          = err_q;
`else
   assign resp_err          = 1'b0;
`endif

endmodule

// File: tb/tb_dram_port_arb.sv
// Bench for dram_port_arb: vector table of single transactions, reset abort,
// four-port fairness and miss-timeout behaviour, with a response scoreboard.
module tb_dram_port_arb;

   localparam int unsigned NP = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic              clk;
   logic              rst;
   logic [NP-1:0]     req_valid;
   logic [NP-1:0]     req_we;
   logic [NP*AW-1:0]  req_addr;
   logic [NP*DW-1:0]  req_wdata;
   logic [NP-1:0]     req_ready;
   logic [NP-1:0]     resp_valid;
   logic [DW-1:0]     resp_rdata;
   logic              resp_err;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     wdata;
   logic [DW-1:0]     rdata;
   logic              write_enable_DRAM;
   logic              read_enable_DRAM;
   logic              miss;

   logic [AW-1:0]     a_arr [NP];
   logic [DW-1:0]     w_arr [NP];

   assign req_addr  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
   assign req_wdata = {w_arr[3], w_arr[2], w_arr[1], w_arr[0]};

   dram_port_arb #(
      .N_PORTS     (NP),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_we            (req_we),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .req_ready         (req_ready),
      .resp_valid        (resp_valid),
      .resp_rdata        (resp_rdata),
      .resp_err          (resp_err),
      .addr              (addr),
      .wdata             (wdata),
      .rdata             (rdata),
      .write_enable_DRAM (write_enable_DRAM),
      .read_enable_DRAM  (read_enable_DRAM),
      .miss              (miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          miss;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic [1:0]  port;
      logic [31:0] rdata;
      logic        err;
   } sb_t;

   vec_t vecs [6];
   sb_t  sb [$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic run_txn(input vec_t v);
      cyc();
      req_valid    = 4'(1) << v.port;
      req_we       = 4'(v.we) << v.port;
      a_arr[v.port] = v.addr;
      w_arr[v.port] = v.wdata;
      miss         = 1'b0;
      rdata        = $urandom;
      @(negedge clk);
      chk("grant", 64'(req_ready), 64'(4'(1) << v.port));
      sb.push_back('{v.port, v.exp_rdata, 1'b0});
      for (int k = 0; k <= v.miss; k++) begin
         cyc();
         req_valid = '0;
         miss      = (k < v.miss);
         rdata     = (k < v.miss) ? $urandom : v.rdata;
         @(negedge clk);
         chk("busy_wen", 64'(write_enable_DRAM), 64'(v.we));
         chk("busy_ren", 64'(read_enable_DRAM), 64'(!v.we));
         chk("busy_addr", 64'(addr), 64'(v.addr));
         chk("busy_wdata", 64'(wdata), 64'(v.wdata));
         chk("busy_ready", 64'(req_ready), 64'(0));
         chk("busy_resp", 64'(resp_valid), 64'(0));
      end
      cyc();
      miss  = 1'b0;
      rdata = $urandom;
      @(negedge clk);
      chk("done_resp", 64'(resp_valid), 64'(4'(1) << v.port));
      chk("done_en", 64'({write_enable_DRAM, read_enable_DRAM}), 64'(0));
      chk("done_ready", 64'(req_ready), 64'(0));
   endtask

   // Scoreboard: every completion pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (resp_valid !== '0) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: resp_valid=%b with nothing outstanding (t=%0t)",
                     resp_valid, $time);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("sb_port", 64'(resp_valid), 64'(4'(1) << e.port));
            chk("sb_rdata", 64'(resp_rdata), 64'(e.rdata));
            chk("sb_err", 64'(resp_err), 64'(e.err));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0] exp_port;

      vecs[0] = '{2'd0, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
      vecs[1] = '{2'd1, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'h0000_0000, 3, 32'hDEAD_BEEF};
      vecs[2] = '{2'd2, 1'b0, 32'h0000_0300, 32'h0000_0000, 32'hCAFE_F00D, 1, 32'hCAFE_F00D};
      vecs[3] = '{2'd3, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0000_0000, 0, 32'hCAFE_F00D};
      vecs[4] = '{2'd0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 2, 32'h0000_0000};
      vecs[5] = '{2'd3, 1'b0, 32'h0000_0044, 32'h0000_0000, 32'h1357_9BDF, 0, 32'h1357_9BDF};

      rst       = 1'b1;
      req_valid = '1;
      req_we    = '0;
      miss      = 1'b0;
      rdata     = '0;
      for (int i = 0; i < NP; i++) begin
         a_arr[i] = '0;
         w_arr[i] = '0;
      end

      // Reset state, with every port requesting.
      cyc();
      cyc();
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_resp", 64'(resp_valid), 64'(0));
      chk("rst_rdata", 64'(resp_rdata), 64'(0));
      chk("rst_err", 64'(resp_err), 64'(0));
      chk("rst_addr", 64'(addr), 64'(0));
      chk("rst_wdata", 64'(wdata), 64'(0));
      chk("rst_wen", 64'(write_enable_DRAM), 64'(0));
      chk("rst_ren", 64'(read_enable_DRAM), 64'(0));
      cyc();
      rst       = 1'b0;
      req_valid = '0;

      for (int i = 0; i < 6; i++) run_txn(vecs[i]);

      // Reset during a stalled read: enables drop at once, no completion.
      cyc();
      req_valid = 4'b0010;
      req_we    = '0;
      a_arr[1]  = 32'h0000_0500;
      @(negedge clk);
      chk("abort_grant", 64'(req_ready), 64'(4'b0010));
      cyc();
      req_valid = '0;
      miss      = 1'b1;
      @(negedge clk);
      chk("abort_busy_ren", 64'(read_enable_DRAM), 64'(1));
      cyc();
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ren", 64'(read_enable_DRAM), 64'(0));
      chk("abort_wen", 64'(write_enable_DRAM), 64'(0));
      cyc();
      @(negedge clk);
      chk("abort_resp", 64'(resp_valid), 64'(0));

      // Release with all ports requesting: port 0 first, then strict rotation.
      cyc();
      rst       = 1'b0;
      miss      = 1'b0;
      req_valid = '1;
      req_we    = '0;
      for (int i = 0; i < NP; i++) a_arr[i] = 32'(i) * 32'h1000 + 32'h40;
      exp_port = 2'd0;
      for (int g = 0; g < 5; g++) begin
         if (g > 0) cyc();
         @(negedge clk);
         chk("fair_grant", 64'(req_ready), 64'(4'(1) << exp_port));
         sb.push_back('{exp_port, 32'hF000_0000 + 32'(g), 1'b0});
         cyc();
         rdata = 32'hF000_0000 + 32'(g);
         @(negedge clk);
         chk("fair_addr", 64'(addr), 64'(32'(exp_port) * 32'h1000 + 32'h40));
         chk("fair_busy_ready", 64'(req_ready), 64'(0));
         cyc();
         @(negedge clk);
         chk("fair_done_ready", 64'(req_ready), 64'(0));
         exp_port = exp_port + 2'd1;
      end
      cyc();
      req_valid = '0;

      // Miss held high on a read from port 2.
      cyc();
      req_valid = 4'b0100;
      a_arr[2]  = 32'h7777_0000;
      @(negedge clk);
      chk("to_grant", 64'(req_ready), 64'(4'b0100));
`ifdef DRAM_ARB_TIMEOUT_EN
      sb.push_back('{2'd2, 32'hF000_0004, 1'b1});
      for (int k = 1; k <= int'(TO); k++) begin
         cyc();
         req_valid = '0;
         miss      = 1'b1;
         rdata     = $urandom;
         @(negedge clk);
         chk("to_busy_ren", 64'(read_enable_DRAM), 64'(1));
         chk("to_busy_resp", 64'(resp_valid), 64'(0));
      end
      cyc();
      @(negedge clk);
      chk("to_abort_resp", 64'(resp_valid), 64'(4'b0100));
      chk("to_abort_ren", 64'(read_enable_DRAM), 64'(0));
      miss = 1'b0;
`else
      sb.push_back('{2'd2, 32'h2468_ACE0, 1'b0});
      for (int k = 1; k <= 100; k++) begin
         cyc();
         req_valid = '0;
         miss      = 1'b1;
         rdata     = $urandom;
         @(negedge clk);
         chk("wait_ren", 64'(read_enable_DRAM), 64'(1));
         chk("wait_resp", 64'(resp_valid), 64'(0));
      end
      cyc();
      miss  = 1'b0;
      rdata = 32'h2468_ACE0;
      @(negedge clk);
      chk("wait_last_ren", 64'(read_enable_DRAM), 64'(1));
      cyc();
      @(negedge clk);
      chk("wait_done_resp", 64'(resp_valid), 64'(4'b0100));
`endif

      cyc();
      cyc();
      @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dram_port_arb.md
DRAM_PORT_ARB -- requirements
Module: dram_port_arb

Interface
REQ-001 SHALL have parameter N_PORTS, default 2; number of requester channels, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32; address width.
REQ-003 SHALL have parameter DATA_W, default 32; data width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024; miss-cycle limit, used only with the timeout option.
REQ-005 SHALL have port clk, input, 1; the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port req_valid, input, N_PORTS; per-port request strobe.
REQ-008 SHALL have port req_we, input, N_PORTS; per-port write select (1 write, 0 read).
REQ-009 SHALL have port req_addr, input, N_PORTS*ADDR_W; packed addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_wdata, input, N_PORTS*DATA_W; packed write data, same packing.
REQ-011 SHALL have port req_ready, output, N_PORTS; grant/accept, one-hot or zero.
REQ-012 SHALL have port resp_valid, output, N_PORTS; one-cycle completion pulse to the owning port.
REQ-013 SHALL have port resp_rdata, output, DATA_W; read data, shared by all ports.
REQ-014 SHALL have port resp_err, output, 1; timeout abort flag, qualified by resp_valid.
REQ-015 SHALL have ports addr (output, ADDR_W), wdata (output, DATA_W), rdata (input, DATA_W), write_enable_DRAM (output, 1), read_enable_DRAM (output, 1) and miss (input, 1); the DRAM side.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-017 In IDLE with any req_valid set, SHALL assert req_ready for exactly one port, chosen by round-robin; the handshake occurs in that cycle.
REQ-018 Round-robin SHALL search from the port after the last granted one, wrapping from N_PORTS-1 to 0.
REQ-019 On the handshake, SHALL latch the port index, we, addr and wdata, then enter BUSY.
REQ-020 In BUSY, SHALL drive the latched addr and wdata; write_enable_DRAM=we and read_enable_DRAM=!we; never both high.
REQ-021 In BUSY, miss SHALL be sampled in the same cycle; miss=1 keeps BUSY with all DRAM outputs held stable.
REQ-022 In BUSY with miss=0, SHALL capture rdata into resp_rdata (reads only), then enter DONE.
REQ-023 In DONE, SHALL pulse resp_valid[owner] for one cycle, deassert both enables, and return to IDLE.
REQ-024 req_ready SHALL be all-zero in BUSY and DONE.
REQ-025 Minimum latency SHALL be: handshake at cycle 0, DRAM access at cycle 1, resp_valid at cycle 2; next grant is possible at cycle 3.
REQ-026 On writes, resp_rdata SHALL hold its previous value.
REQ-027 Request inputs for a port that is not granted SHALL be ignored; requesters SHALL hold req_valid until req_ready.

Reset
REQ-028 While rst is high, SHALL hold: state IDLE, req_ready 0, resp_valid 0, resp_rdata 0, resp_err 0, addr 0, wdata 0, both enables 0, round-robin pointer N_PORTS-1 (port 0 has first priority).
REQ-029 Reset asserted mid-BUSY SHALL drop both enables immediately, with no resp_valid for the aborted access.

Configuration
REQ-030 Macro DRAM_ARB_TIMEOUT_EN defined: SHALL count consecutive BUSY cycles with miss=1; on reaching TIMEOUT_CYC, SHALL abort to DONE with resp_err=1 and leave resp_rdata unchanged.
REQ-031 Macro not defined: SHALL include no counter, tie resp_err to 0, and allow BUSY to wait indefinitely.

Structure
REQ-032 Package dram_arb_pkg SHALL hold the state enum, default width constants and the packing-offset helper.
REQ-033 Round-robin grant logic SHALL be sub-module rr_arbiter (parameter N, inputs req/last, output one-hot grant).

Verification
REQ-034 Single read: port0 reads 0x100, miss=0, rdata=0xDEADBEEF -> read_enable_DRAM high at cycle 1; resp_valid[0] and resp_rdata=0xDEADBEEF at cycle 2.
REQ-035 Miss stall: write 0x200/0x12345678 with miss high for 3 cycles -> addr and wdata stable for 4 BUSY cycles; resp_valid one cycle after miss falls.
REQ-036 Fairness: N_PORTS=4, all ports requesting continuously -> grant order 0,1,2,3,0.
REQ-037 Reset mid-op: rst high during BUSY with miss=1 -> enables drop the same cycle; no resp_valid; port 0 wins after release.
REQ-038 Timeout (macro on, TIMEOUT_CYC=8): miss held high -> resp_valid with resp_err=1 after 8 BUSY cycles; macro off -> still BUSY at cycle 100.
